scc_wave_mixer_5ch: RTL
=======================

Name: scc_wave_mixer_5ch

Overview:
Downstream consumer of the 5-channel time-multiplexed tone generator. For each active channel slot it reads one signed 8-bit sample from the wave RAM, using the per-slot wave_address. It scales the sample by that channel's 4-bit volume and accumulates the five products. When the channel-E product has been added, it emits one signed mixed sample per frame to the output/DAC stage.

Parameters:
SHARE_DE, 1, when 1 channel E (slot 4) reads channel D's wave table (ram_address channel field = 3); when 0 it reads its own table (field = 4)
OUT_WIDTH, 15, signed width of mixed output; must be >= 15 (no saturation needed at 15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
active  in  3  current channel slot; 0..4 = channels A..E, 5..7 = idle
wave_address  in  5  wave position of the active channel, valid in the same cycle as active
reg_volume_a  in  4  channel A volume, unsigned 0..15 (likewise _b.._e, five ports total)
reg_enable  in  5  per-channel enable, bit0 = A .. bit4 = E
ram_address  out  8  {channel[2:0], wave_address[4:0]}, combinational from active/wave_address
ram_data  in  8  signed wave sample, valid the cycle after ram_address (synchronous RAM)
sample_out  out  OUT_WIDTH  signed mixed sample, held between updates
sample_valid  out  1  one-cycle pulse when sample_out updates

Behaviour:
- Reset (clk edge with reset=1): sample_out=0, sample_valid=0, accumulator=0, all pipeline valid bits=0. Applies mid-frame: any partial frame is discarded, and the next frame must begin with a fresh slot-0 entry or it is accumulated from zero.
- Stage 0 (cycle t, active=k<=4):
  - ram_address = {ch, wave_address}; ch=k, except k=4 with SHARE_DE=1 gives ch=3.
  - At the clk edge, register valid=1, slot tag=k, vol=reg_volume_k, en=reg_enable[k].
  - For active>=5: ram_address = {active, wave_address}, don't-care to RAM; valid=0.
- Stage 1 (cycle t+1): product = signed(ram_data) × unsigned(vol), 12-bit signed, forced to 0 when en=0. At the clk edge, register product, valid, and last = (tag==4).
- Stage 2 (cycle t+2), only when valid:
  - last=0: acc <= acc + product (sign-extended to OUT_WIDTH).
  - last=1: sample_out <= acc + product; acc <= 0; sample_valid <= 1.
  - When stage 2 is not valid: acc holds, sample_valid <= 0.
- Latency: active=4 in cycle t gives sample_valid=1 and the new sample_out in cycle t+3.
- Range: the worst case sum is -9600..+9525, so 15-bit signed never overflows.
- Slot order is not checked. Every slot-4 entry closes a frame. Repeated or missing slots are accumulated as they arrive. Idle slots (5..7) add nothing and do not stall.
- Volume and enable are sampled in stage 0. A change during a frame affects only later slots.
- The pipeline is fully pipelined, one slot per cycle, with no backpressure.

Test Plan:
- All RAM samples=+127, all vol=15, enable=5'b11111, slots 0..5 repeating -> sample_out=9525, sample_valid one cycle, 3 cycles after active=4.
- All samples=-128 (0x80), vol=15, all enabled -> sample_out=-9600; consecutive frames give identical values and one pulse per frame.
- Samples A..E = 10,20,30,40,50, vol=1, enable=5'b10101 -> sample_out=10+30+50=90 (with SHARE_DE=0 and a distinct E table).
- SHARE_DE=1, active=4, wave_address=5'd7 -> ram_address=8'h67; SHARE_DE=0 -> 8'h87; active=2, addr=31 -> 8'h5F.
- Assert reset after slots 0..2 of a frame, release, run a full frame of all +1, vol=1 -> first sample_out=5 (no leftover), sample_out=0 and sample_valid=0 while in reset.
- Change reg_volume_a 15->0 while active=3 -> current frame still uses 15 for A; next frame uses 0.

Source files
------------

// File: rtl/scc_wave_mixer_5ch.sv
// scc_wave_mixer_5ch: scales each active slot's wave sample by its volume
// and sums five channels into one signed mixed sample per frame.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   active, wave_address   current slot (0..4 = A..E, 5..7 idle) and position
//   reg_volume_a.._e       4-bit unsigned channel volumes
//   reg_enable             per-channel enable, bit0 = A .. bit4 = E
//   ram_address, ram_data  wave RAM port; data arrives one cycle after address
//   sample_out             signed mixed sample, held between frames
//   sample_valid           one-cycle pulse when sample_out updates

module scc_wave_mixer_5ch #(
  parameter bit SHARE_DE  = 1'b1,
  parameter int OUT_WIDTH = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  active,
  input  logic [4:0]                  wave_address,
  input  logic [3:0]                  reg_volume_a,
  input  logic [3:0]                  reg_volume_b,
  input  logic [3:0]                  reg_volume_c,
  input  logic [3:0]                  reg_volume_d,
  input  logic [3:0]                  reg_volume_e,
  input  logic [4:0]                  reg_enable,
  output logic [7:0]                  ram_address,
  input  logic [7:0]                  ram_data,
  output logic signed [OUT_WIDTH-1:0] sample_out,
  output logic                        sample_valid
);

  typedef struct packed {
    logic       valid;
    logic [2:0] tag;
    logic [3:0] vol;
    logic       en;
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic               last;
    logic signed [11:0] prod;
  } s2_t;

  s1_t s1;
  s2_t s2;

  logic signed [OUT_WIDTH-1:0] acc;

  // Stage 0: address and per-slot control
  logic [2:0] ram_ch;
  logic [3:0] vol_sel;
  logic       en_sel;
  logic       slot_ok;

  always_comb begin
    ram_ch = active;
    // Channel E may share channel D's wave table
    if (SHARE_DE && active == 3'd4) ram_ch = 3'd3;
  end

  assign ram_address = {ram_ch, wave_address};
  assign slot_ok     = (active < 3'd5);

  always_comb begin
    vol_sel = '0;
    en_sel  = 1'b0;
    case (active)
      3'd0: begin vol_sel = reg_volume_a; en_sel = reg_enable[0]; end
      3'd1: begin vol_sel = reg_volume_b; en_sel = reg_enable[1]; end
      3'd2: begin vol_sel = reg_volume_c; en_sel = reg_enable[2]; end
      3'd3: begin vol_sel = reg_volume_d; en_sel = reg_enable[3]; end
      3'd4: begin vol_sel = reg_volume_e; en_sel = reg_enable[4]; end
      default: ;
    endcase
  end

  // Stage 1: signed sample times unsigned volume.
  // 12 bits hold -128*15 .. 127*15 exactly, so the
  // truncated 12-bit product is the true value.
  logic signed [11:0] smp_ext;
  logic signed [11:0] vol_ext;
  logic signed [11:0] prod;

  always_comb begin
    smp_ext = {{4{ram_data[7]}}, ram_data};
    vol_ext = {8'b0, s1.vol};
    prod    = s1.en ? (smp_ext * vol_ext) : '0;
  end

  // Stage 2: accumulate, close frame on slot 4
  logic signed [OUT_WIDTH-1:0] prod_ext;
  logic signed [OUT_WIDTH-1:0] sum;

  always_comb begin
    prod_ext = {{(OUT_WIDTH-12){s2.prod[11]}}, s2.prod};
    sum      = acc + prod_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= '0;
      s2           <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      s1.valid     <= slot_ok;
      s1.tag       <= active;
      s1.vol       <= vol_sel;
      s1.en        <= en_sel;
      s2.valid     <= s1.valid;
      s2.last      <= (s1.tag == 3'd4);
      s2.prod      <= prod;
      sample_valid <= 1'b0;
      if (s2.valid) begin
        if (s2.last) begin
          sample_out   <= sum;
          acc          <= '0;
          sample_valid <= 1'b1;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule
